// File: rtl/fetch_pkg.sv
// fetch_pkg: shared register-file types, PC index, bubble encoding and fetch FSM states.
//   regval_t/regind_t/regfile_t : register file typing, registers[PC] is the program counter
//   BUBBLE_INSN                 : word decode always rejects (bit31=1, mask=0)
//   DEPTH                       : instruction buffer depth, 2 when FETCH_PREFETCH_EN is defined, else 1
package fetch_pkg;
  typedef logic [31:0] regval_t;
  typedef logic [3:0] regind_t;
  typedef regval_t [15:0] regfile_t;
  localparam regind_t PC = 4'd15;
  localparam regval_t BUBBLE_INSN = 32'h8000_0000;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  typedef enum logic [1:0] {RUN, WAIT_ACK, STALLED, RESTART} fetch_state_t;
endpackage

// File: rtl/i_fetch_to_decode.sv
// i_fetch_to_decode: fetch -> decode handshake.
//   instruction    : next instruction word (BUBBLE_INSN when none)
//   hold           : decode stall, freezes instruction
//   is_pc_changing : control transfer in flight, fetch must flush and stall
interface i_fetch_to_decode;
  logic [31:0] instruction;
  logic hold;
  logic is_pc_changing;
  modport fetch_out(output instruction, input hold, is_pc_changing);
  modport decode_in(input instruction, output hold, is_pc_changing);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry instruction FIFO, head always in the lowest slot.
//   clock, reset_n : clock and async active-low reset (clears count only)
//   push, data     : write data behind the current entries
//   pop            : drop head, remaining entries shift down
//   flush          : empty the buffer, overrides push and pop
//   head, count    : oldest entry and occupancy 0..DEPTH
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  regval_t    data,
  output regval_t    head,
  output logic [1:0] count
);
  logic [DEPTH*32-1:0] q, q_n;
  // A simultaneous pop shifts first, so the new word lands one slot lower.
  always_comb begin
    q_n = pop ? q >> 32 : q;
    for (int i = 0; i < DEPTH; i++)
      if (push && i == int'(count) - int'(pop)) q_n[i*32 +: 32] = data;
  end
  always_ff @(posedge clock) q <= q_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= flush ? '0 : count + 2'(push) - 2'(pop);
  assign head = q[31:0];
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage, word-addressed memory requests into a small FIFO feeding decode.
//   clock, reset_n       : clock and async active-low reset
//   registers            : register file, only registers[PC] is read (on restart)
//   pc_written           : writeback pulse, PC register updated this cycle
//   mem_address/mem_read : request, held stable until mem_ack
//   mem_data/mem_ack     : response, ack may arrive in the request cycle
//   outi                 : instruction to decode, hold and is_pc_changing from decode
//   FETCH_PREFETCH_EN    : two-entry buffer fetching ahead during hold; default one entry
module fetch
  import fetch_pkg::*;
#(
  parameter regval_t BUBBLE = BUBBLE_INSN
) (
  input  logic       clock,
  input  logic       reset_n,
  input  regfile_t   registers,
  input  logic       pc_written,
  output logic [31:0] mem_address,
  output logic       mem_read,
  input  logic [31:0] mem_data,
  input  logic       mem_ack,
  i_fetch_to_decode.fetch_out outi
);
  fetch_state_t state, state_n;
  regval_t fetch_pc, head, instruction;
  logic [1:0] count;
  logic flush, hold, pop, push, space, pending, pc_seen, unused_regs;
  assign flush = outi.is_pc_changing;
  assign hold = outi.hold;
  assign pop = !hold && !flush && count != 0;
`ifdef FETCH_PREFETCH_EN
  assign space = count < 2'(DEPTH);
`else
  assign space = count == 0 || pop;
`endif
  // Data is kept only for live requests; a flush in the ack cycle discards it.
  assign push = mem_read && mem_ack && !flush && (state == RUN || state == WAIT_ACK);
  assign unused_regs = ^registers;
  assign outi.instruction = instruction;
  // pending: a request abandoned by a flush is still held until its ack.
  always_comb begin
    state_n = state;
    mem_read = 1'b0;
    mem_address = state == RESTART ? '0 : fetch_pc;
    case (state)
      RUN: begin
        mem_read = space;
        state_n = flush ? STALLED : space && !mem_ack ? WAIT_ACK : RUN;
      end
      WAIT_ACK: begin
        mem_read = 1'b1;
        state_n = flush ? STALLED : mem_ack ? RUN : WAIT_ACK;
      end
      STALLED: begin
        mem_read = pending;
        state_n = !flush && (pc_written || pc_seen) && !(pending && !mem_ack) ? RESTART : STALLED;
      end
      RESTART: state_n = flush ? STALLED : RUN;
    endcase
  end
  // pc_seen remembers a pc_written that arrived while the discarded ack was still due.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RESTART;
      fetch_pc <= '0;
      pending <= 1'b0;
      pc_seen <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= state == RESTART ? registers[PC] : push ? fetch_pc + 32'd1 : fetch_pc;
      pending <= state_n == STALLED && mem_read && !mem_ack;
      pc_seen <= state_n == STALLED && !flush && (pc_seen || (state == STALLED && pc_written));
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) instruction <= BUBBLE;
    else if (flush) instruction <= BUBBLE;
    else if (!hold) instruction <= count != 0 ? head : BUBBLE;
  fetch_buffer u_buf (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .data(mem_data),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for fetch with a latency-programmable memory and instruction scoreboard.
module tb_fetch;
  import fetch_pkg::*;
  typedef struct {
    logic [31:0] pc;
    int lat;
    int quota;
    int first;
    int last;
  } vec_t;
`ifdef FETCH_PREFETCH_EN
  localparam int HOLD_FETCHES = 2;
`else
  localparam int HOLD_FETCHES = 1;
`endif
  logic clock = 0, reset_n = 1, pc_written = 0, mem_read, mem_ack = 0;
  regfile_t registers = '0;
  logic [31:0] mem_address, mem_data = '0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = '0, req_addr = '0;
  int lat = 0, quota = 0, served = 0, wait_cnt = 0, cyc = 0, first_out = -1, last_out = -1;
  int n_chk = 0, n_fail = 0;
  bit req_dropped = 0, new_out = 0;
  i_fetch_to_decode ifc();
  fetch dut (
    .clock(clock),
    .reset_n(reset_n),
    .registers(registers),
    .pc_written(pc_written),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_data(mem_data),
    .mem_ack(mem_ack),
    .outi(ifc)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {1'b0, a[30:0]} ^ 32'h2C00_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clock) new_out = reset_n && !ifc.hold && !ifc.is_pc_changing;
  always @(negedge clock) begin
    if (new_out && ifc.instruction !== BUBBLE_INSN) begin
      if (exp_q.size() == 0) chk("instr_unexpected", ifc.instruction, BUBBLE_INSN);
      else chk("instr_order", ifc.instruction, exp_q.pop_front());
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    mem_ack = 0;
    if (reset_n && mem_read) begin
      if (ifc.is_pc_changing) req_dropped = 1;
      if (wait_cnt > 0) chk("addr_stable", mem_address, req_addr);
      req_addr = mem_address;
      if (served < quota && wait_cnt >= lat) begin
        mem_ack = 1;
        mem_data = word(mem_address);
        wait_cnt = 0;
        if (req_dropped) req_dropped = 0;
        else begin
          chk("fetch_addr", mem_address, exp_addr);
          exp_addr = exp_addr + 32'd1;
          exp_q.push_back(word(mem_address));
          served++;
        end
      end else wait_cnt++;
    end else begin
      wait_cnt = 0;
      req_dropped = 0;
    end
    cyc++;
  end
  task automatic do_reset(input logic [31:0] pc, input int l, input int q);
    reset_n = 0;
    quota = 0;
    served = 0;
    exp_q.delete();
    first_out = -1;
    last_out = -1;
    lat = l;
    repeat (2) @(posedge clock);
    registers[PC] = pc;
    exp_addr = pc;
    #1 reset_n = 1;
    cyc = 0;
    quota = q;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic mid;
    @(negedge clock);
    #1;
  endtask
  task automatic drain(input string name);
    int i = 0;
    while (i < 200 && !(served == quota && exp_q.size() == 0)) begin
      @(posedge clock);
      i++;
    end
    #1;
    chk({name, "_served"}, served, quota);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[5];
    v[0] = '{32'h0000_0100, 0, 3, 3, 5};
    v[1] = '{32'h0000_0040, 1, 3, 4, 8};
    v[2] = '{32'h0000_7FF0, 3, 2, 6, 10};
    v[3] = '{32'hFFFF_FFFE, 0, 4, 3, 6};
    v[4] = '{32'h0000_0000, 2, 2, 5, 8};
    ifc.hold = 0;
    ifc.is_pc_changing = 0;
    #1 reset_n = 0;
    #1;
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_instruction", ifc.instruction, BUBBLE_INSN);
    foreach (v[k]) begin
      do_reset(v[k].pc, v[k].lat, v[k].quota);
      drain($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_first", k), first_out, v[k].first);
      chk($sformatf("vec%0d_last", k), last_out, v[k].last);
    end
    ifc.hold = 1;
    do_reset(32'h300, 0, 6);
    step(4);
    mid();
    chk("hold_fetches", served, HOLD_FETCHES);
    chk("hold_mem_read", mem_read, 0);
    chk("hold_instruction", ifc.instruction, BUBBLE_INSN);
    step(1);
    ifc.hold = 0;
    drain("hold");
    chk("hold_first", first_out, 6);
    do_reset(32'h40, 3, 3);
    step(2);
    ifc.is_pc_changing = 1;
    step(1);
    ifc.is_pc_changing = 0;
    mid();
    chk("flush_mem_read", mem_read, 1);
    chk("flush_mem_address", mem_address, 32'h40);
    chk("flush_instruction", ifc.instruction, BUBBLE_INSN);
    step(2);
    mid();
    chk("stalled_mem_read", mem_read, 0);
    step(1);
    registers[PC] = 32'h200;
    exp_addr = 32'h200;
    pc_written = 1;
    ifc.is_pc_changing = 1;
    step(1);
    pc_written = 0;
    ifc.is_pc_changing = 0;
    step(1);
    mid();
    chk("pcw_flush_stays", mem_read, 0);
    step(1);
    pc_written = 1;
    step(1);
    pc_written = 0;
    step(1);
    mid();
    chk("restart_mem_read", mem_read, 1);
    chk("restart_mem_address", mem_address, 32'h200);
    drain("flush");
    do_reset(32'h500, 0, 1);
    step(3);
    mid();
    chk("pre_reset_mem_read", mem_read, 1);
    chk("pre_reset_instruction", ifc.instruction, word(32'h500));
    reset_n = 0;
    #1;
    chk("async_mem_read", mem_read, 0);
    chk("async_instruction", ifc.instruction, BUBBLE_INSN);
    chk("async_mem_address", mem_address, 0);
    do_reset(32'h600, 1, 2);
    drain("post_reset");
    chk("post_reset_first", first_out, 4);
    chk("post_reset_last", last_out, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port: clock  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: registers  input  regfile_t  register file; only registers[PC] read.
REQ-004 SHALL have port: pc_written  input  1  one-cycle pulse from writeback, PC updated this cycle.
REQ-005 SHALL have port: mem_address  output  32  instruction word address.
REQ-006 SHALL have port: mem_read  output  1  read request, held until mem_ack.
REQ-007 SHALL have port: mem_data  input  32  instruction word, valid with mem_ack.
REQ-008 SHALL have port: mem_ack  input  1  request accepted and mem_data valid, same cycle.
REQ-009 SHALL have port: outi  i_fetch_to_decode.fetch_out  -  instruction (out 32), hold (in), is_pc_changing (in).
REQ-010 SHALL have parameter: BUBBLE, 32'h8000_0000, encoding decode always treats as invalid (bit31=1, mask=0).

Function
REQ-011 SHALL keep fetch_pc (32 bits, word address), incremented by 1 per mem_ack, wrapping 32'hFFFF_FFFF -> 0.
REQ-012 SHALL keep instruction FIFO, depth DEPTH (see Configuration); count 0..DEPTH.
REQ-013 SHALL run FSM states RUN, WAIT_ACK, STALLED, RESTART.
REQ-014 RUN: mem_read=1 when FIFO not full; mem_address=fetch_pc; go WAIT_ACK if no mem_ack this cycle.
REQ-015 WAIT_ACK: keep mem_read and mem_address stable; on mem_ack push mem_data, increment fetch_pc, return RUN.
REQ-016 SHALL push mem_data into FIFO in the mem_ack cycle; zero-cycle ack allowed in RUN.
REQ-017 When outi.hold=0: outi.instruction <= FIFO head and pop, or BUBBLE if FIFO empty.
REQ-018 When outi.hold=1: outi.instruction, FIFO head and pops frozen; fetching continues until FIFO full.
REQ-019 Push and pop same cycle SHALL leave count unchanged; pop from empty and push to full never occur.
REQ-020 outi.is_pc_changing=1 SHALL flush FIFO, set outi.instruction <= BUBBLE, go STALLED; wins over push, pop and hold.
REQ-021 Flush during WAIT_ACK SHALL keep mem_read asserted until mem_ack, then discard data; no fetch_pc update.
REQ-022 STALLED: mem_read=0 once no request outstanding; output BUBBLE each non-held cycle; wait for pc_written.
REQ-023 pc_written SHALL move STALLED -> RESTART; pc_written and is_pc_changing same cycle SHALL stay STALLED.
REQ-024 RESTART: fetch_pc <= registers[PC]; go RUN next cycle; pc_written outside STALLED ignored.
REQ-025 Latency: memory with 0-cycle ack SHALL give instruction at outi two cycles after request issue when FIFO empty.

Reset
REQ-026 reset_n low SHALL asynchronously force: state RESTART, FIFO count 0, outi.instruction=BUBBLE, mem_read=0, mem_address=0.
REQ-027 Reset mid-request SHALL abandon the outstanding read; first request after reset SHALL use registers[PC].

Configuration
REQ-028 Macro FETCH_PREFETCH_EN defined: DEPTH=2, requests issue while count<2, including during outi.hold.
REQ-029 Macro FETCH_PREFETCH_EN undefined: DEPTH=1, request issues only when FIFO empty or popping this cycle.

Structure
REQ-030 regfile_t, regval_t, regind_t, PC index, and BUBBLE constant SHALL live in the shared package.
REQ-031 Fetch state enum SHALL live in the shared package.
REQ-032 FIFO SHALL be sub-module fetch_buffer (push, pop, flush, data, count); FSM and fetch_pc stay in fetch.

Verification
REQ-033 Reset, registers[PC]=32'h100, 0-cycle ack -> mem_address 0x100,0x101,0x102; outi.instruction matches mem_data in order.
REQ-034 3-cycle ack latency -> mem_address stable 3 cycles; BUBBLE emitted while FIFO empty.
REQ-035 hold=1 for 4 cycles, FETCH_PREFETCH_EN -> exactly 2 fetches then mem_read=0; hold release -> both drained in order.
REQ-036 is_pc_changing during WAIT_ACK -> late mem_data discarded, BUBBLE output; pc_written with PC=0x200 -> next mem_address 0x200.
REQ-037 fetch_pc=32'hFFFF_FFFF with ack -> next mem_address 0.
REQ-038 reset_n low mid-WAIT_ACK -> mem_read=0 and outi.instruction=BUBBLE immediately, without waiting for a clock edge.
